// File: rtl/vga_ctrl_regs.sv
// ---------------------------------------------------------------------------
// vga_ctrl_regs
//   CPU-facing I/O register block in front of the VGA timing/memory
//   controller. It holds the display mode and plane, turns the controller's
//   vsync pulse into a vertical-blank interrupt and a frame counter, and
//   (optionally) derives the text-blink phase from vsync.
//
//   Register window (4 bytes, selected by _vga_io):
//     0 CTRL   R/W  [1:0] mode, [2] plane, [3] irq_en, [7:4] read 0
//     1 STATUS R    [0] pending, [1] synced vsync level
//              W    bit0=1 clears pending
//     2 FRAME  RO   8-bit frame counter (wraps)
//     3 BLINK  R/W  blink period in frames (0 = blink disabled)
//
//   Optional feature macro: VGA_BLINK_EN
//     defined   : blink generator and BLINK register present
//     undefined : register 3 reads 8'h00, writes ignored, blink tied to 1
//
//   Ports:
//     clock    in   system clock (shared with the VGA controller)
//     _reset   in   asynchronous active-low reset
//     _vga_io  in   active-low register-window select
//     addr     in   [1:0] register select
//     _rd      in   active-low read strobe
//     _wr      in   active-low write strobe
//     data     io   [7:0] CPU data bus, driven only during reads
//     vsync    in   vsync pulse from the VGA controller
//     mode     out  [1:0] graphics mode to the VGA controller
//     plane    out  displayed memory plane
//     irq      out  vertical-blank interrupt request
//     blink    out  text blink phase (1 = visible)
//
//   Write handshake: the CPU strobe is asynchronous to clock. While the
//   synchronised _wr and _vga_io are both low, the synchronised addr/data are
//   captured every cycle and wr_valid is set. The single commit happens on
//   the cycle the synchronised _wr goes high while wr_valid is set; dropping
//   _vga_io before _wr rises does not cancel it.
// ---------------------------------------------------------------------------
module vga_ctrl_regs #(
  parameter logic [7:0] BLINK_DEFAULT = 8'd0
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       _vga_io,
  input  logic [1:0] addr,
  input  logic       _rd,
  input  logic       _wr,
  inout  wire  [7:0] data,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       plane,
  output logic       irq,
  output logic       blink
);

  // Two-flop synchronisers
  logic       r_wr_s1, r_wr_s2, r_wr_prev;
  logic       r_io_s1, r_io_s2;
  logic [1:0] r_addr_s1, r_addr_s2;
  logic [7:0] r_data_s1, r_data_s2;
  logic       r_vs_s1, r_vs_s2, r_vs_prev;

  // Write capture
  logic       r_wr_valid;
  logic [1:0] r_wr_addr;
  logic [7:0] r_wr_data;

  // Architectural registers
  logic [1:0] r_mode;
  logic       r_plane;
  logic       r_irq_en;
  logic       r_pending;
  logic [7:0] r_frame;

  logic       w_commit;
  logic       w_vs_edge;
  logic [7:0] w_rd_data;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      // Strobes reset to their inactive level so no false edge follows reset
      r_wr_s1   <= 1'b1;
      r_wr_s2   <= 1'b1;
      r_wr_prev <= 1'b1;
      r_io_s1   <= 1'b1;
      r_io_s2   <= 1'b1;
      r_addr_s1 <= 2'd0;
      r_addr_s2 <= 2'd0;
      r_data_s1 <= 8'd0;
      r_data_s2 <= 8'd0;
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_wr_s1   <= _wr;
      r_wr_s2   <= r_wr_s1;
      r_wr_prev <= r_wr_s2;
      r_io_s1   <= _vga_io;
      r_io_s2   <= r_io_s1;
      r_addr_s1 <= addr;
      r_addr_s2 <= r_addr_s1;
      r_data_s1 <= data;
      r_data_s2 <= r_data_s1;
      r_vs_s1   <= vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
    end
  end

  assign w_commit  = r_wr_s2 & ~r_wr_prev & r_wr_valid;
  assign w_vs_edge = r_vs_s2 & ~r_vs_prev;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 2'd0;
      r_wr_data  <= 8'd0;
    end else if (!r_wr_s2 && !r_io_s2) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= r_addr_s2;
      r_wr_data  <= r_data_s2;
    end else if (w_commit) begin
      r_wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_mode   <= 2'd0;
      r_plane  <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_commit && r_wr_addr == 2'd0) begin
      r_mode   <= r_wr_data[1:0];
      r_plane  <= r_wr_data[2];
      r_irq_en <= r_wr_data[3];
    end
  end

  // A vsync edge in the same cycle as a STATUS clear keeps pending set
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_pending <= 1'b0;
    end else if (w_vs_edge) begin
      r_pending <= 1'b1;
    end else if (w_commit && r_wr_addr == 2'd1 && r_wr_data[0]) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_frame <= 8'd0;
    end else if (w_vs_edge) begin
      r_frame <= r_frame + 8'd1;
    end
  end

`ifdef VGA_BLINK_EN
  logic [7:0] r_period;
  logic [7:0] r_bcnt;
  logic       r_blink;

  // A BLINK write restarts the phase and overrides a same-cycle vsync edge
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_period <= BLINK_DEFAULT;
      r_bcnt   <= 8'd0;
      r_blink  <= 1'b1;
    end else if (w_commit && r_wr_addr == 2'd3) begin
      r_period <= r_wr_data;
      r_bcnt   <= 8'd0;
      r_blink  <= 1'b1;
    end else if (r_period == 8'd0) begin
      r_bcnt   <= 8'd0;
      r_blink  <= 1'b1;
    end else if (w_vs_edge) begin
      if (r_bcnt == r_period - 8'd1) begin
        r_bcnt  <= 8'd0;
        r_blink <= ~r_blink;
      end else begin
        r_bcnt  <= r_bcnt + 8'd1;
      end
    end
  end

  assign blink = r_blink;
`else
  logic [7:0] w_unused_blink_default;
  assign w_unused_blink_default = BLINK_DEFAULT;
  assign blink = 1'b1;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    case (addr)
      2'd0: w_rd_data = {4'b0000, r_irq_en, r_plane, r_mode};
      2'd1: w_rd_data = {6'b000000, r_vs_s2, r_pending};
      2'd2: w_rd_data = r_frame;
`ifdef VGA_BLINK_EN
      2'd3: w_rd_data = r_period;
`else
      2'd3: w_rd_data = 8'h00;
`endif
      default: w_rd_data = 8'h00;
    endcase
  end

  // Read path uses the raw strobes so the CPU sees data within its cycle
  assign data  = (!_vga_io && !_rd) ? w_rd_data : 8'bz;

  assign mode  = r_mode;
  assign plane = r_plane;
  assign irq   = r_pending & r_irq_en;

endmodule

// File: tb/tb_vga_ctrl_regs.sv
module tb_vga_ctrl_regs;

  logic       clock;
  logic       _reset;
  logic       _vga_io;
  logic [1:0] addr;
  logic       _rd;
  logic       _wr;
  wire  [7:0] data;
  logic       vsync;
  logic [1:0] mode;
  logic       plane;
  logic       irq;
  logic       blink;

  logic [7:0] drv_data;
  logic       drv_en;
  logic [7:0] rd_val;

  int checks;
  int errors;

  assign data = drv_en ? drv_data : 8'bz;

  vga_ctrl_regs #(.BLINK_DEFAULT(8'd0)) dut (
    .clock   (clock),
    ._reset  (_reset),
    ._vga_io (_vga_io),
    .addr    (addr),
    ._rd     (_rd),
    ._wr     (_wr),
    .data    (data),
    .vsync   (vsync),
    .mode    (mode),
    .plane   (plane),
    .irq     (irq),
    .blink   (blink)
  );

  // clock / reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock);
    _vga_io = 1'b0; addr = a; drv_data = d; drv_en = 1'b1;
    @(negedge clock);
    _wr = 1'b0;
    repeat (10) @(negedge clock);
    _wr = 1'b1;
    @(negedge clock);
    _vga_io = 1'b1; drv_en = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clock);
    addr = a; _vga_io = 1'b0; _rd = 1'b0;
    #2;
    v = data;
    _vga_io = 1'b1; _rd = 1'b1;
  endtask

  task automatic vsync_pulse();
    @(negedge clock);
    vsync = 1'b1;
    repeat (3) @(negedge clock);
    vsync = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #5 _reset = 1'b0;
    #20 _reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0;
    _reset = 1'b1; _vga_io = 1'b1; addr = 2'd0; _rd = 1'b1; _wr = 1'b1;
    vsync = 1'b0; drv_data = 8'h00; drv_en = 1'b0;

    // reset
    pulse_reset();
    check("rst_mode",  {6'd0, mode}, 8'h00);
    check("rst_plane", {7'd0, plane}, 8'h00);
    check("rst_irq",   {7'd0, irq}, 8'h00);
    check("rst_blink", {7'd0, blink}, 8'h01);
    // bus released by DUT: a bench-driven value passes unchanged
    drv_data = 8'hA5; drv_en = 1'b1; #2;
    check("rst_bus_released", data, 8'hA5);
    drv_en = 1'b0;
    cpu_read(2'd2, rd_val); check("rst_frame", rd_val, 8'h00);
    cpu_read(2'd0, rd_val); check("rst_ctrl", rd_val, 8'h00);
    cpu_read(2'd1, rd_val); check("rst_status", rd_val, 8'h00);

    // CTRL write 0E, commit two cycles after _wr rises
    @(negedge clock);
    _vga_io = 1'b0; addr = 2'd0; drv_data = 8'h0E; drv_en = 1'b1;
    @(negedge clock);
    _wr = 1'b0;
    repeat (10) @(negedge clock);
    _wr = 1'b1;
    @(negedge clock);
    _vga_io = 1'b1; drv_en = 1'b0;
    @(negedge clock);
    check("ctrl_precommit_mode", {6'd0, mode}, 8'h00);
    @(negedge clock);
    check("ctrl_mode",  {6'd0, mode}, 8'h02);
    check("ctrl_plane", {7'd0, plane}, 8'h01);
    check("ctrl_irq_nopend", {7'd0, irq}, 8'h00);
    cpu_read(2'd0, rd_val); check("ctrl_read", rd_val, 8'h0E);

    // irq latency: edge sampled at posedge k -> pending after k+2
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("irq_k1", {7'd0, irq}, 8'h00);
    @(negedge clock);
    check("irq_k2", {7'd0, irq}, 8'h01);
    cpu_read(2'd1, rd_val); check("status_vs_high", rd_val, 8'h03);
    vsync = 1'b0;
    repeat (4) @(negedge clock);
    cpu_read(2'd1, rd_val); check("status_vs_low", rd_val, 8'h01);
    cpu_write(2'd1, 8'h01);
    check("irq_cleared", {7'd0, irq}, 8'h00);
    cpu_read(2'd1, rd_val); check("status_cleared", rd_val, 8'h00);

    // clear commit coincides with vsync edge: set wins
    @(negedge clock);
    _vga_io = 1'b0; addr = 2'd1; drv_data = 8'h01; drv_en = 1'b1;
    @(negedge clock);
    _wr = 1'b0;
    repeat (10) @(negedge clock);
    _wr = 1'b1; vsync = 1'b1;
    @(negedge clock);
    _vga_io = 1'b1; drv_en = 1'b0;
    repeat (4) @(negedge clock);
    check("irq_set_wins", {7'd0, irq}, 8'h01);
    cpu_read(2'd1, rd_val); check("status_set_wins", rd_val, 8'h03);
    vsync = 1'b0;
    repeat (4) @(negedge clock);
    cpu_read(2'd2, rd_val); check("frame_two", rd_val, 8'h02);
    cpu_write(1'b1 ? 2'd1 : 2'd1, 8'h01);
    check("irq_cleared2", {7'd0, irq}, 8'h00);

    // FRAME writes ignored
    cpu_write(2'd2, 8'h55);
    cpu_read(2'd2, rd_val); check("frame_ro", rd_val, 8'h02);

    // deselect one clock before _wr rises: write still commits
    @(negedge clock);
    _vga_io = 1'b0; addr = 2'd0; drv_data = 8'h05; drv_en = 1'b1;
    @(negedge clock);
    _wr = 1'b0;
    repeat (10) @(negedge clock);
    _vga_io = 1'b1;
    @(negedge clock);
    _wr = 1'b1;
    @(negedge clock);
    drv_en = 1'b0;
    repeat (4) @(negedge clock);
    check("desel_mode",  {6'd0, mode}, 8'h01);
    check("desel_plane", {7'd0, plane}, 8'h01);
    cpu_read(2'd0, rd_val); check("desel_ctrl", rd_val, 8'h05);

    // reset during a write: the write is lost
    @(negedge clock);
    _vga_io = 1'b0; addr = 2'd0; drv_data = 8'h03; drv_en = 1'b1;
    @(negedge clock);
    _wr = 1'b0;
    repeat (4) @(negedge clock);
    #5 _reset = 1'b0;
    @(negedge clock);
    _wr = 1'b1; _vga_io = 1'b1; drv_en = 1'b0;
    repeat (3) @(negedge clock);
    _reset = 1'b1;
    repeat (4) @(negedge clock);
    check("rstwr_mode", {6'd0, mode}, 8'h00);
    cpu_read(2'd0, rd_val); check("rstwr_ctrl", rd_val, 8'h00);
    cpu_read(2'd2, rd_val); check("rstwr_frame", rd_val, 8'h00);

    // frame wrap
    for (int i = 0; i < 256; i++) vsync_pulse();
    cpu_read(2'd2, rd_val); check("frame_wrap", rd_val, 8'h00);
    vsync_pulse();
    cpu_read(2'd2, rd_val); check("frame_257", rd_val, 8'h01);
    check("irq_disabled", {7'd0, irq}, 8'h00);

`ifdef VGA_BLINK_EN
    cpu_write(2'd3, 8'h03);
    cpu_read(2'd3, rd_val); check("blink_period", rd_val, 8'h03);
    check("blink_start", {7'd0, blink}, 8'h01);
    begin
      logic [5:0] exp_seq;
      exp_seq = 6'b100011; // bit i = blink after pulse i+1: 1,1,0,0,0,1
      for (int i = 0; i < 6; i++) begin
        vsync_pulse();
        check($sformatf("blink_p%0d", i + 1), {7'd0, blink}, {7'd0, exp_seq[i]});
      end
    end
    vsync_pulse(); // blink now 1 -> 1 (count 1)
    vsync_pulse(); // count 2
    vsync_pulse(); // toggles to 0
    check("blink_low_before_off", {7'd0, blink}, 8'h00);
    cpu_write(2'd3, 8'h00);
    check("blink_off", {7'd0, blink}, 8'h01);
    for (int i = 0; i < 4; i++) vsync_pulse();
    check("blink_off_hold", {7'd0, blink}, 8'h01);
`else
    cpu_write(2'd3, 8'h03);
    cpu_read(2'd3, rd_val); check("blink_reg_absent", rd_val, 8'h00);
    for (int i = 0; i < 3; i++) vsync_pulse();
    check("blink_tied", {7'd0, blink}, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
